// File: rtl/cpu_ctrl_pkg.sv
// Purpose: shared constants for the CPU run/step/halt sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

  localparam int PC_W                = 32;
  localparam int DIV_MAX_DEF         = 50000000;
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } run_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Purpose: 2-FF synchronizer, stable-count debouncer and rising-edge pulse for a push button.
// Latency: 2 Clk sync + DEBOUNCE_CYCLES stable samples + 1 Clk to rise_evt.
// Backpressure: none; rise_evt is a single-Clk pulse that is never queued.
//
// Ports:
//   Clk, Rst   clock and asynchronous active-high reset
//   btn_raw    raw asynchronous button input
//   rise_evt   one-Clk pulse when the debounced level goes 0 -> 1
module btn_debounce
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic Clk,
  input  logic Rst,
  input  logic btn_raw,
  output logic rise_evt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          btn_meta;
  logic          btn_sync;
  logic          level;
  logic [CW-1:0] stable_cnt;

  // stable_cnt counts consecutive synced samples that disagree with the
  // accepted level; any agreeing sample restarts the count.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      btn_meta   <= 1'b0;
      btn_sync   <= 1'b0;
      level      <= 1'b0;
      stable_cnt <= '0;
      rise_evt   <= 1'b0;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
      rise_evt <= 1'b0;
      if (btn_sync == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        level      <= btn_sync;
        stable_cnt <= '0;
        rise_evt   <= btn_sync;
      end else begin
        stable_cnt <= stable_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Purpose: run/step/halt sequencer issuing a one-Clk cpu_ce per CPU cycle, with cycle counter.
// Latency: cpu_ce registered 1 Clk after the decision; run_sw 2 Clk sync; RUN ticks every DIV_MAX Clk.
// Backpressure: none; halt_req/breakpoint stop RUN immediately, step events outside HALT are dropped.
//
// Ports:
//   Clk, Rst            clock and asynchronous active-high reset
//   run_sw, step_btn    asynchronous switch / raw push button
//   halt_req            synchronous halt request level
//   pc, bp_addr, bp_valid  breakpoint compare inputs
//   cpu_ce              core clock enable pulse
//   state, halted       sequencer state (HALT=0, RUN=1, STEP=2) and HALT flag
//   bp_hit              sticky breakpoint-stop flag
//   cycle_count         number of cpu_ce pulses issued (wraps)
// Build option: define CPU_RUN_CTRL_BREAKPOINT_EN to enable PC breakpoints;
// otherwise pc/bp_addr/bp_valid are ignored and bp_hit is constant 0.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DIV_MAX         = DIV_MAX_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt_req,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_valid,
  output logic             cpu_ce,
  output logic [1:0]       state,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DIV_W = $clog2(DIV_MAX);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_MAX - 1);

  logic             run_meta;
  logic             run_s;
  logic             step_evt;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             run_lock;
  logic             bp_stop;
  run_state_t       st_q;
  run_state_t       st_d;
  logic             ce_d;
  logic             lock_set;
  logic             bp_set;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_db (
    .Clk      (Clk),
    .Rst      (Rst),
    .btn_raw  (step_btn),
    .rise_evt (step_evt)
  );

  assign tick  = (div_cnt == DIV_LAST);
  assign state = st_q;

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  // Only a tick that would execute the instruction at bp_addr is stopped.
  assign bp_stop = bp_valid && (pc == bp_addr) && tick;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      bp_hit <= 1'b0;
    end else if (bp_set) begin
      bp_hit <= 1'b1;
    end else if ((st_q == HALT) && (st_d != HALT)) begin
      bp_hit <= 1'b0;
    end
  end
`else
  logic unused_bp;
  assign bp_stop   = 1'b0;
  assign bp_hit    = 1'b0;
  assign unused_bp = ^{pc, bp_addr, bp_valid, bp_set};
`endif

  always_comb begin
    st_d     = st_q;
    ce_d     = 1'b0;
    lock_set = 1'b0;
    bp_set   = 1'b0;
    case (st_q)
      HALT: begin
        if (run_s && !run_lock) begin
          st_d = RUN;
        end else if (step_evt) begin
          // cpu_ce rises together with STEP so the pulse lines up with it.
          st_d = STEP;
          ce_d = 1'b1;
        end
      end
      STEP: begin
        st_d = HALT;
      end
      RUN: begin
        if (halt_req || bp_stop) begin
          st_d     = HALT;
          lock_set = 1'b1;
          bp_set   = bp_stop;
        end else if (!run_s) begin
          st_d = HALT;
        end else begin
          ce_d = tick;
        end
      end
      default: begin
        st_d = HALT;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      st_q        <= HALT;
      halted      <= 1'b1;
      cpu_ce      <= 1'b0;
      cycle_count <= '0;
      run_meta    <= 1'b0;
      run_s       <= 1'b0;
      div_cnt     <= '0;
      run_lock    <= 1'b0;
    end else begin
      st_q     <= st_d;
      halted   <= (st_d == HALT);
      cpu_ce   <= ce_d;
      run_meta <= run_sw;
      run_s    <= run_meta;
      if (ce_d) begin
        cycle_count <= cycle_count + CNT_W'(1);
      end
      // Divider only runs while staying in RUN, so every RUN entry starts at 0.
      if ((st_q == RUN) && (st_d == RUN)) begin
        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      end else begin
        div_cnt <= '0;
      end
      // A forced stop must win over the clear so a stop seen with run_s low
      // still needs the switch to be observed low afterwards.
      if (lock_set) begin
        run_lock <= 1'b1;
      end else if (!run_s) begin
        run_lock <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Purpose: self-checking bench for cpu_run_ctrl (DIV_MAX=4, DEBOUNCE_CYCLES=8, CNT_W=4).
// Latency: n/a.
// Backpressure: n/a.
module tb_cpu_run_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        run_sw, step_btn, halt_req, bp_valid;
  logic [31:0] pc, bp_addr;
  logic        cpu_ce, halted, bp_hit;
  logic [1:0]  state;
  logic [3:0]  cycle_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [3:0] exp_count;

  typedef struct {
    int         cyc;
    logic [3:0] cnt;
    logic [1:0] st;
  } pulse_t;

  pulse_t exp_q[$];
  pulse_t obs_q[$];

  cpu_run_ctrl #(
    .DIV_MAX(4),
    .DEBOUNCE_CYCLES(8),
    .CNT_W(4)
  ) dut (
    .Clk(Clk), .Rst(Rst), .run_sw(run_sw), .step_btn(step_btn),
    .halt_req(halt_req), .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
    .cpu_ce(cpu_ce), .state(state), .halted(halted), .bp_hit(bp_hit),
    .cycle_count(cycle_count)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Advance n cycles, sampling at negedge; each cpu_ce pulse is logged and
  // advances the bench's program counter model.
  task automatic clk_n(input int n);
    repeat (n) begin
      @(negedge Clk);
      if (cpu_ce === 1'b1) begin
        pulse_t p;
        p.cyc = cyc;
        p.cnt = cycle_count;
        p.st  = state;
        obs_q.push_back(p);
        pc = pc + 32'd4;
      end
    end
  endtask

  task automatic push_exp(input int c, input logic [1:0] st);
    pulse_t p;
    exp_count = exp_count + 4'd1;
    p.cyc = c;
    p.cnt = exp_count;
    p.st  = st;
    exp_q.push_back(p);
  endtask

  task automatic wait_state(input logic [1:0] s, input int bound, output int n);
    n = 0;
    while (state !== s && n < bound) begin
      clk_n(1);
      n++;
    end
  endtask

  task automatic test_reset;
    Rst = 1'b1; run_sw = 0; step_btn = 0; halt_req = 0;
    pc = 0; bp_addr = 0; bp_valid = 0; exp_count = 0;
    #12;
    total++; if (cpu_ce !== 1'b0) begin bad++; $display("FAIL reset_ce: got %0b want 0", cpu_ce); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL reset_halted: got %0b want 1", halted); end
    total++; if (bp_hit !== 1'b0) begin bad++; $display("FAIL reset_bp_hit: got %0b want 0", bp_hit); end
    total++; if (cycle_count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", cycle_count); end
    @(negedge Clk);
    Rst = 1'b0;
    clk_n(2);
  endtask

  task automatic test_run;
    int n, entry;
    exp_q.delete(); obs_q.delete();
    run_sw = 1'b1;
    wait_state(2'd1, 8, n);
    total++; if (n < 2 || n > 3) begin bad++; $display("FAIL run_entry_latency: got %0d want 2..3", n); end
    entry = cyc;
    for (int k = 1; k <= 4; k++) push_exp(entry + 4 * k, 2'd1);
    clk_n(16);
    total++; if (cycle_count !== exp_count) begin bad++; $display("FAIL run_count16: got %0d want %0d", cycle_count, exp_count); end
    while (exp_q.size() > 0) begin
      pulse_t e, o;
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL run_pulse: got none want cnt=%0d cyc=%0d", e.cnt, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.cnt !== e.cnt || o.st !== e.st || o.cyc != e.cyc) begin
          bad++; $display("FAIL run_pulse: got cnt=%0d st=%0d cyc=%0d want cnt=%0d st=%0d cyc=%0d", o.cnt, o.st, o.cyc, e.cnt, e.st, e.cyc);
        end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL run_extra: got %0d extra pulses want 0", obs_q.size()); end
  endtask

  task automatic test_async_reset;
    int n = 0;
    while (cpu_ce !== 1'b1 && n < 8) begin @(negedge Clk); n++; end
    total++; if (cpu_ce !== 1'b1) begin bad++; $display("FAIL areset_pulse_seen: got %0b want 1", cpu_ce); end
    #2 Rst = 1'b1;
    #1;
    total++; if (cpu_ce !== 1'b0) begin bad++; $display("FAIL areset_ce: got %0b want 0", cpu_ce); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL areset_state: got %0d want 0", state); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL areset_halted: got %0b want 1", halted); end
    total++; if (cycle_count !== 4'd0) begin bad++; $display("FAIL areset_count: got %0d want 0", cycle_count); end
    run_sw = 1'b0;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    exp_count = 0;
    clk_n(3);
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_step;
    logic bounce_val[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 4; i++) begin step_btn = bounce_val[i]; clk_n(3); end
    step_btn = 1'b1;
    push_exp(-1, 2'd2);
    clk_n(30);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL step_state: got %0d want 0", state); end
    total++; if (cycle_count !== exp_count) begin bad++; $display("FAIL step_count: got %0d want %0d", cycle_count, exp_count); end
    step_btn = 1'b0;
    clk_n(20);
    while (exp_q.size() > 0) begin
      pulse_t e, o;
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL step_pulse: got none want cnt=%0d", e.cnt); end
      else begin
        o = obs_q.pop_front();
        if (o.cnt !== e.cnt || o.st !== e.st) begin
          bad++; $display("FAIL step_pulse: got cnt=%0d st=%0d want cnt=%0d st=%0d", o.cnt, o.st, e.cnt, e.st);
        end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL step_extra: got %0d extra pulses want 0", obs_q.size()); end
    obs_q.delete();
    step_btn = 1'b1; clk_n(5);
    step_btn = 1'b0; clk_n(20);
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL glitch_pulses: got %0d want 0", obs_q.size()); end
    total++; if (cycle_count !== exp_count) begin bad++; $display("FAIL glitch_count: got %0d want %0d", cycle_count, exp_count); end
  endtask

  task automatic test_halt_req;
    int n;
    exp_q.delete(); obs_q.delete();
    run_sw = 1'b1;
    wait_state(2'd1, 8, n);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL halt_run_entry: got %0d want 1", state); end
    push_exp(cyc + 4, 2'd1);
    clk_n(7);
    halt_req = 1'b1;
    clk_n(1);
    halt_req = 1'b0;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL halt_state: got %0d want 0", state); end
    total++; if (cpu_ce !== 1'b0) begin bad++; $display("FAIL halt_no_ce: got %0b want 0", cpu_ce); end
    clk_n(10);
    total++; if (state !== 2'd0 || halted !== 1'b1) begin bad++; $display("FAIL halt_locked: got state=%0d halted=%0b want 0/1", state, halted); end
    run_sw = 1'b0; clk_n(4);
    run_sw = 1'b1;
    wait_state(2'd1, 8, n);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL halt_rerun: got %0d want 1", state); end
    run_sw = 1'b0;
    wait_state(2'd0, 8, n);
    while (exp_q.size() > 0) begin
      pulse_t e, o;
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL halt_pulse: got none want cnt=%0d", e.cnt); end
      else begin
        o = obs_q.pop_front();
        if (o.cnt !== e.cnt || o.cyc != e.cyc) begin
          bad++; $display("FAIL halt_pulse: got cnt=%0d cyc=%0d want cnt=%0d cyc=%0d", o.cnt, o.cyc, e.cnt, e.cyc);
        end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL halt_extra: got %0d extra pulses want 0", obs_q.size()); end
  endtask

  task automatic test_breakpoint;
    int n;
    exp_q.delete(); obs_q.delete();
    pc = 32'd0; bp_addr = 32'h0000_000C; bp_valid = 1'b1;
    run_sw = 1'b1;
    wait_state(2'd1, 8, n);
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    for (int k = 0; k < 3; k++) push_exp(-1, 2'd1);
    wait_state(2'd0, 30, n);
    total++; if (state !== 2'd0 || halted !== 1'b1) begin bad++; $display("FAIL bp_halt: got state=%0d halted=%0b want 0/1", state, halted); end
    total++; if (bp_hit !== 1'b1) begin bad++; $display("FAIL bp_hit_set: got %0b want 1", bp_hit); end
    total++; if (pc !== 32'h0000_000C) begin bad++; $display("FAIL bp_pc: got %0h want c", pc); end
    clk_n(5);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL bp_locked: got %0d want 0", state); end
    push_exp(-1, 2'd2);
    step_btn = 1'b1; clk_n(20);
    step_btn = 1'b0; clk_n(12);
    total++; if (bp_hit !== 1'b0) begin bad++; $display("FAIL bp_hit_clear: got %0b want 0", bp_hit); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL bp_step_state: got %0d want 0", state); end
    run_sw = 1'b0; clk_n(4);
`else
    for (int k = 0; k < 5; k++) push_exp(-1, 2'd1);
    clk_n(20);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL nobp_running: got %0d want 1", state); end
    total++; if (bp_hit !== 1'b0) begin bad++; $display("FAIL nobp_hit: got %0b want 0", bp_hit); end
    total++; if (pc !== 32'h0000_0014) begin bad++; $display("FAIL nobp_pc: got %0h want 14", pc); end
    run_sw = 1'b0; clk_n(4);
`endif
    bp_valid = 1'b0;
    while (exp_q.size() > 0) begin
      pulse_t e, o;
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL bp_pulse: got none want cnt=%0d", e.cnt); end
      else begin
        o = obs_q.pop_front();
        if (o.cnt !== e.cnt || o.st !== e.st) begin
          bad++; $display("FAIL bp_pulse: got cnt=%0d st=%0d want cnt=%0d st=%0d", o.cnt, o.st, e.cnt, e.st);
        end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL bp_extra: got %0d extra pulses want 0", obs_q.size()); end
  endtask

  task automatic test_wrap;
    int n;
    @(negedge Clk); Rst = 1'b1;
    @(negedge Clk); Rst = 1'b0;
    exp_count = 0;
    exp_q.delete(); obs_q.delete();
    total++; if (cycle_count !== 4'd0) begin bad++; $display("FAIL wrap_start: got %0d want 0", cycle_count); end
    run_sw = 1'b1;
    wait_state(2'd1, 8, n);
    for (int k = 0; k < 17; k++) push_exp(-1, 2'd1);
    n = 0;
    while (obs_q.size() < 17 && n < 100) begin clk_n(1); n++; end
    run_sw = 1'b0;
    total++; if (cycle_count !== 4'd1) begin bad++; $display("FAIL wrap_end: got %0d want 1", cycle_count); end
    clk_n(6);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL wrap_halt: got %0d want 0", state); end
    while (exp_q.size() > 0) begin
      pulse_t e, o;
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL wrap_pulse: got none want cnt=%0d", e.cnt); end
      else begin
        o = obs_q.pop_front();
        if (o.cnt !== e.cnt) begin bad++; $display("FAIL wrap_pulse: got cnt=%0d want cnt=%0d", o.cnt, e.cnt); end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL wrap_extra: got %0d extra pulses want 0", obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_async_reset();
    test_step();
    test_halt_req();
    test_breakpoint();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
